// File: rtl/bayer_frame_ctrl.sv
// Frame sequencer feeding a Bayer interpolator: lines of H_RES beats, inter-line blanking, EOF pulse.
// Define BAYER_FRAME_CTRL_FLUSH_EN to append one zero-data flush line that drains the interpolator.
module bayer_frame_ctrl #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_PIXELS     = 1
) (
  input  logic                               SYS_CLK_I,
  input  logic                               RESETN_I,
  input  logic                               FRAME_START_I,
  input  logic [15:0]                        H_RES_I,
  input  logic [15:0]                        V_RES_I,
  input  logic [7:0]                         BLANK_I,
  input  logic [1:0]                         BAYER_FORMAT_I,
  input  logic                               PIX_VALID_I,
  input  logic [G_PIXELS*G_DATA_WIDTH-1:0]   PIX_DATA_I,
  output logic                               PIX_READY_O,
  output logic                               DATA_VALID_O,
  output logic [G_PIXELS*G_DATA_WIDTH-1:0]   DATA_O,
  output logic                               EOF_O,
  output logic [1:0]                         BAYER_FORMAT_O,
  output logic                               BUSY_O,
  output logic                               FRAME_DONE_O,
  output logic                               ERR_O
);

  typedef enum logic [2:0] {S_IDLE, S_LINE, S_BLANK, S_FLUSH, S_EOF} state_t;

`ifdef BAYER_FRAME_CTRL_FLUSH_EN
  localparam state_t S_TAIL = S_FLUSH;
`else
  localparam state_t S_TAIL = S_EOF;
`endif

  state_t      state;
  logic [15:0] h_res_q, v_res_q, hcnt, vcnt;
  logic [7:0]  blank_q, bcnt;
  logic [1:0]  rst_sync;
  logic        rst_n;

  // Assert immediately, release two clocks after RESETN_I rises.
  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic start_ok, last_beat, last_line_now, last_line_done;
  assign start_ok       = FRAME_START_I && (H_RES_I != 16'd0) && (V_RES_I != 16'd0);
  assign last_beat      = (hcnt == h_res_q - 16'd1);
  assign last_line_now  = (vcnt == v_res_q - 16'd1);
  // In BLANK vcnt has already advanced past the completed line.
  assign last_line_done = (vcnt == v_res_q);

  assign PIX_READY_O = (state == S_LINE);

  always_ff @(posedge SYS_CLK_I or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      h_res_q        <= '0;
      v_res_q        <= '0;
      blank_q        <= '0;
      hcnt           <= '0;
      vcnt           <= '0;
      bcnt           <= '0;
      DATA_VALID_O   <= 1'b0;
      DATA_O         <= '0;
      EOF_O          <= 1'b0;
      BAYER_FORMAT_O <= '0;
      BUSY_O         <= 1'b0;
      FRAME_DONE_O   <= 1'b0;
      ERR_O          <= 1'b0;
    end else begin
      DATA_VALID_O <= 1'b0;
      EOF_O        <= 1'b0;
      FRAME_DONE_O <= 1'b0;
      ERR_O        <= FRAME_START_I && !(state == S_IDLE && start_ok);
      case (state)
        S_IDLE: if (start_ok) begin
          h_res_q        <= H_RES_I;
          v_res_q        <= V_RES_I;
          blank_q        <= BLANK_I;
          BAYER_FORMAT_O <= BAYER_FORMAT_I;
          hcnt           <= '0;
          vcnt           <= '0;
          bcnt           <= '0;
          BUSY_O         <= 1'b1;
          state          <= S_LINE;
        end
        S_LINE: if (PIX_VALID_I) begin
          DATA_VALID_O <= 1'b1;
          DATA_O       <= PIX_DATA_I;
          if (last_beat) begin
            hcnt <= '0;
            vcnt <= vcnt + 16'd1;
            bcnt <= '0;
            if (blank_q != 8'd0) state <= S_BLANK;
            else                 state <= last_line_now ? S_TAIL : S_LINE;
          end else begin
            hcnt <= hcnt + 16'd1;
          end
        end
        S_BLANK: begin
          if (bcnt == blank_q - 8'd1) state <= last_line_done ? S_TAIL : S_LINE;
          else                        bcnt  <= bcnt + 8'd1;
        end
`ifdef BAYER_FRAME_CTRL_FLUSH_EN
        S_FLUSH: begin
          DATA_VALID_O <= 1'b1;
          DATA_O       <= '0;
          if (last_beat) begin
            hcnt  <= '0;
            state <= S_EOF;
          end else begin
            hcnt <= hcnt + 16'd1;
          end
        end
`endif
        S_EOF: begin
          EOF_O        <= 1'b1;
          FRAME_DONE_O <= 1'b1;
          BUSY_O       <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// Scoreboard bench for bayer_frame_ctrl: driver pushes expected beats, a negedge monitor pops and compares.
module tb_bayer_frame_ctrl;
  localparam int DW = 8;
  localparam int NP = 1;
  localparam int W  = DW * NP;
`ifdef BAYER_FRAME_CTRL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         RESETN_I = 1'b1;
  logic         FRAME_START_I = 1'b0;
  logic [15:0]  H_RES_I = '0, V_RES_I = '0;
  logic [7:0]   BLANK_I = '0;
  logic [1:0]   BAYER_FORMAT_I = '0;
  logic         PIX_VALID_I = 1'b0;
  logic [W-1:0] PIX_DATA_I = '0;
  logic         PIX_READY_O, DATA_VALID_O, EOF_O, BUSY_O, FRAME_DONE_O, ERR_O;
  logic [W-1:0] DATA_O;
  logic [1:0]   BAYER_FORMAT_O;

  always #5 clk = ~clk;

  bayer_frame_ctrl #(.G_DATA_WIDTH(DW), .G_PIXELS(NP)) dut (
    .SYS_CLK_I(clk), .RESETN_I(RESETN_I), .FRAME_START_I(FRAME_START_I),
    .H_RES_I(H_RES_I), .V_RES_I(V_RES_I), .BLANK_I(BLANK_I),
    .BAYER_FORMAT_I(BAYER_FORMAT_I), .PIX_VALID_I(PIX_VALID_I), .PIX_DATA_I(PIX_DATA_I),
    .PIX_READY_O(PIX_READY_O), .DATA_VALID_O(DATA_VALID_O), .DATA_O(DATA_O),
    .EOF_O(EOF_O), .BAYER_FORMAT_O(BAYER_FORMAT_O), .BUSY_O(BUSY_O),
    .FRAME_DONE_O(FRAME_DONE_O), .ERR_O(ERR_O));

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  bit           trace_q[$];
  bit           trace_arm = 1'b0;
  bit           arm_q = 1'b0, tr_on = 1'b0, tr_done = 1'b0;
  int           eof_cnt = 0;
  logic [W-1:0] dcnt = W'(16);

  function automatic void chk(input bit ok, input string name, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endfunction

  // Monitor: data scoreboard, EOF/DONE pairing and DATA_VALID_O trace capture.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (DATA_VALID_O) begin
      if (exp_q.size() == 0) chk(1'b0, "unexpected_beat", DATA_O, 0);
      else begin
        e = exp_q.pop_front();
        chk(DATA_O == e, "beat_data", DATA_O, e);
      end
    end
    if (EOF_O || FRAME_DONE_O) chk(EOF_O == FRAME_DONE_O, "eof_done_pair", FRAME_DONE_O, EOF_O);
    if (EOF_O) eof_cnt++;
    if (trace_arm && !arm_q) begin
      trace_q.delete();
      tr_on = 1'b0;
      tr_done = 1'b0;
    end
    arm_q = trace_arm;
    if (trace_arm && !tr_done) begin
      if (!tr_on && DATA_VALID_O) tr_on = 1'b1;
      if (tr_on) begin
        if (EOF_O) begin tr_done = 1'b1; tr_on = 1'b0; end
        else trace_q.push_back(DATA_VALID_O);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input int h, input int v, input int b, input int f);
    FRAME_START_I = 1'b1;
    H_RES_I = 16'(h); V_RES_I = 16'(v); BLANK_I = 8'(b); BAYER_FORMAT_I = 2'(f);
    cyc();
    FRAME_START_I = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int acc = 0;
    int it = 0;
    while (acc < n && it < 1000) begin
      PIX_VALID_I = toggle ? ((it % 2) == 0) : 1'b1;
      PIX_DATA_I  = dcnt;
      @(negedge clk);
      chk(BUSY_O == 1'b1, "busy_in_frame", BUSY_O, 1);
      if (PIX_READY_O && PIX_VALID_I) begin
        exp_q.push_back(PIX_DATA_I);
        dcnt = dcnt + W'(1);
        acc++;
      end
      cyc();
      it++;
    end
    PIX_VALID_I = 1'b0;
    if (acc < n) chk(1'b0, "feed_timeout", acc, n);
  endtask

  task automatic push_flush(input int h);
    if (FLUSH_EN) for (int i = 0; i < h; i++) exp_q.push_back('0);
  endtask

  task automatic wait_eof(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (EOF_O) got = 1'b1;
    end
    chk(got, name, got, 1);
    cyc();
    chk(exp_q.size() == 0, {name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk(DATA_VALID_O == 0,   {tag, "_dv"},    DATA_VALID_O, 0);
    chk(DATA_O == '0,        {tag, "_data"},  DATA_O, 0);
    chk(EOF_O == 0,          {tag, "_eof"},   EOF_O, 0);
    chk(BAYER_FORMAT_O == 0, {tag, "_fmt"},   BAYER_FORMAT_O, 0);
    chk(BUSY_O == 0,         {tag, "_busy"},  BUSY_O, 0);
    chk(FRAME_DONE_O == 0,   {tag, "_done"},  FRAME_DONE_O, 0);
    chk(ERR_O == 0,          {tag, "_err"},   ERR_O, 0);
    chk(PIX_READY_O == 0,    {tag, "_ready"}, PIX_READY_O, 0);
  endtask

  initial begin
    bit exp_tr[$];
    bit ok;
    int n0;

    #2 RESETN_I = 1'b0;
    repeat (2) cyc();
    check_zero("reset");
    RESETN_I = 1'b1;
    repeat (3) cyc();

    // H=4 V=2 BLANK=3 continuous input: valid pattern 4/3/4/3 (+4 flush)
    trace_arm = 1'b1;
    start_frame(4, 2, 3, 2);
    feed(8, 1'b0);
    push_flush(4);
    wait_eof("eof_a");
    trace_arm = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) exp_tr.push_back(1'b1);
      for (int i = 0; i < 3; i++) exp_tr.push_back(1'b0);
    end
    if (FLUSH_EN) for (int i = 0; i < 4; i++) exp_tr.push_back(1'b1);
    ok = tr_done && (trace_q.size() == exp_tr.size());
    if (ok) for (int i = 0; i < exp_tr.size(); i++) if (trace_q[i] != exp_tr[i]) ok = 1'b0;
    chk(ok, "dv_pattern_len", trace_q.size(), exp_tr.size());
    chk(BAYER_FORMAT_O == 2'd2, "fmt_frame_a", BAYER_FORMAT_O, 2);

    // H=4 V=1 BLANK=0 toggling valid; start during EOF state is rejected, next cycle accepted
    start_frame(4, 1, 0, 0);
    feed(4, 1'b1);
    push_flush(4);
`ifdef BAYER_FRAME_CTRL_FLUSH_EN
    wait_eof("eof_b");
    start_frame(4, 1, 2, 1);
`else
    FRAME_START_I = 1'b1;
    H_RES_I = 16'd4; V_RES_I = 16'd1; BLANK_I = 8'd2; BAYER_FORMAT_I = 2'd1;
    cyc();
    @(negedge clk);
    chk(ERR_O == 1'b1, "err_start_in_eof", ERR_O, 1);
    chk(EOF_O == 1'b1, "eof_b", EOF_O, 1);
    cyc();
    FRAME_START_I = 1'b0;
`endif
    chk(BAYER_FORMAT_O == 2'd1, "fmt_accept_c", BAYER_FORMAT_O, 1);

    // Mid-line start with new format/size is rejected; latched values kept
    feed(2, 1'b0);
    FRAME_START_I = 1'b1; BAYER_FORMAT_I = 2'd3; H_RES_I = 16'd7;
    cyc();
    FRAME_START_I = 1'b0;
    @(negedge clk);
    chk(ERR_O == 1'b1, "err_mid_line", ERR_O, 1);
    chk(BAYER_FORMAT_O == 2'd1, "fmt_hold_mid", BAYER_FORMAT_O, 1);
    cyc();
    @(negedge clk);
    chk(ERR_O == 1'b0, "err_one_pulse", ERR_O, 0);
    cyc();
    feed(2, 1'b0);
    push_flush(4);
    wait_eof("eof_c");
    chk(BAYER_FORMAT_O == 2'd1, "fmt_after_c", BAYER_FORMAT_O, 1);

    // Zero resolution starts
    start_frame(4, 0, 1, 2);
    @(negedge clk);
    chk(ERR_O == 1'b1, "err_zero_v", ERR_O, 1);
    chk(BUSY_O == 1'b0, "busy_zero_v", BUSY_O, 0);
    chk(PIX_READY_O == 1'b0, "ready_zero_v", PIX_READY_O, 0);
    cyc();
    start_frame(0, 2, 1, 2);
    @(negedge clk);
    chk(ERR_O == 1'b1, "err_zero_h", ERR_O, 1);
    chk(BUSY_O == 1'b0, "busy_zero_h", BUSY_O, 0);
    chk(BAYER_FORMAT_O == 2'd1, "fmt_after_reject", BAYER_FORMAT_O, 1);
    cyc();

    // Reset during the second line aborts without EOF; next frame runs fully
    n0 = eof_cnt;
    start_frame(4, 3, 1, 3);
    feed(5, 1'b0);
    RESETN_I = 1'b0;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    repeat (3) cyc();
    RESETN_I = 1'b1;
    repeat (20) cyc();
    chk(eof_cnt == n0, "no_eof_after_abort", eof_cnt, n0);
    start_frame(2, 2, 1, 1);
    feed(4, 1'b0);
    push_flush(2);
    wait_eof("eof_after_reset");
    chk(eof_cnt == n0 + 1, "eof_count_after_reset", eof_cnt, n0 + 1);
    chk(BAYER_FORMAT_O == 2'd1, "fmt_after_reset", BAYER_FORMAT_O, 1);

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
